// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The entry layout matches how fetch_queue packs its storage words.
package fetch_queue_pkg;

   localparam int          FQ_WORD_W        = 32;
   localparam int          FQ_DEFAULT_DEPTH = 4;
   localparam logic [31:0] FQ_NOP           = 32'h0000_0000;
   localparam logic [31:0] FQ_PC_INC        = 32'd4;

   typedef struct packed {
      logic [FQ_WORD_W-1:0] pc;
      logic [FQ_WORD_W-1:0] pc_plus4;
      logic [FQ_WORD_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// DEPTH x ENTRY_W register array for the fetch queue.
// It supports write-at-pointer, read-at-pointer and a synchronous clear of every entry.
module fq_storage
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH   = FQ_DEFAULT_DEPTH,
   parameter int ENTRY_W = 3 * FQ_WORD_W,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               we,
   input  logic [PTR_W-1:0]   wr_ptr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [PTR_W-1:0]   rd_ptr,
   output logic [ENTRY_W-1:0] rd_data
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (clr) begin
            mem_d[i] = '0;
         end else if (we && (wr_ptr == PTR_W'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   // The head is read straight from the flops, so decode sees it in the same cycle as Count.
   assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch buffer between the PC register / instruction memory and decode.
// It drives PC+4 and PC_EN so that fetch stalls only when the buffer is full.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEFAULT_DEPTH,
   parameter int WIDTH = FQ_WORD_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] PC_F,
   input  logic [WIDTH-1:0] Instr_F,
   output logic [WIDTH-1:0] PCPlus4_F,
   output logic             PC_EN,
   input  logic             Flush_D,
   input  logic             Stall_D,
   output logic             Valid_D,
   output logic [WIDTH-1:0] Instr_D,
   output logic [WIDTH-1:0] PC_D,
   output logic [WIDTH-1:0] PCPlus4_D,
   output logic [CNT_W-1:0] Count
);

   localparam int ENTRY_W = 3 * WIDTH;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic               valid;
   logic               full;
   logic               push;
   logic               pop;
   logic               clr;
   logic [WIDTH-1:0]   pc_plus4;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;

   assign pc_plus4 = PC_F + WIDTH'(FQ_PC_INC);
   assign valid    = (count_q != '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop      = valid & ~Stall_D & ~Flush_D;
   assign push     = RST & ~Flush_D & (~full | pop);
   assign clr      = ~RST | Flush_D;
   assign wr_entry = {PC_F, pc_plus4, Instr_F};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Flush_D) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by plain overflow.
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fq_storage #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_storage (
      .clk     (CLK),
      .clr     (clr),
      .we      (push),
      .wr_ptr  (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_ptr  (rd_ptr_q),
      .rd_data (head_entry)
   );

   assign PCPlus4_F = pc_plus4;
   assign PC_EN     = RST & (push | Flush_D);
   assign Valid_D   = valid;
   assign Count     = count_q;

   // An empty queue presents a NOP to decode rather than stale storage contents.
   assign PC_D      = valid ? head_entry[ENTRY_W-1 -: WIDTH]   : WIDTH'(FQ_NOP);
   assign PCPlus4_D = valid ? head_entry[2*WIDTH-1 -: WIDTH]   : WIDTH'(FQ_NOP);
   assign Instr_D   = valid ? head_entry[WIDTH-1:0]            : WIDTH'(FQ_NOP);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue: table-driven cycles plus a short hand sequence
// covering reset-with-flush and the PC+4 wrap.
module tb_fetch_queue;

   logic        CLK;
   logic        RST;
   logic [31:0] PC_F;
   logic [31:0] Instr_F;
   logic [31:0] PCPlus4_F;
   logic        PC_EN;
   logic        Flush_D;
   logic        Stall_D;
   logic        Valid_D;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PCPlus4_D;
   logic [2:0]  Count;

   fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .PC_F      (PC_F),
      .Instr_F   (Instr_F),
      .PCPlus4_F (PCPlus4_F),
      .PC_EN     (PC_EN),
      .Flush_D   (Flush_D),
      .Stall_D   (Stall_D),
      .Valid_D   (Valid_D),
      .Instr_D   (Instr_D),
      .PC_D      (PC_D),
      .PCPlus4_D (PCPlus4_D),
      .Count     (Count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst;
      logic        flush;
      logic        stall;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exp_pc_en;
      logic        exp_valid;
      logic [2:0]  exp_count;
      logic [31:0] exp_instr_d;
      logic [31:0] exp_pc_d;
      logic [31:0] exp_pc4_d;
      logic [31:0] exp_pc4_f;
   } vec_t;

   vec_t vec_q[$];
   int   checks;
   int   errors;

   task automatic add(input logic rst, input logic flush, input logic stall,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic pc_en, input logic valid, input logic [2:0] count,
                      input logic [31:0] instr_d, input logic [31:0] pc_d,
                      input logic [31:0] pc4_d, input logic [31:0] pc4_f);
      vec_t v;
      v.rst = rst; v.flush = flush; v.stall = stall; v.pc = pc; v.instr = instr;
      v.exp_pc_en = pc_en; v.exp_valid = valid; v.exp_count = count;
      v.exp_instr_d = instr_d; v.exp_pc_d = pc_d; v.exp_pc4_d = pc4_d; v.exp_pc4_f = pc4_f;
      vec_q.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input vec_t v);
      chk("PC_EN",     idx, {31'd0, PC_EN},   {31'd0, v.exp_pc_en});
      chk("Valid_D",   idx, {31'd0, Valid_D}, {31'd0, v.exp_valid});
      chk("Count",     idx, {29'd0, Count},   {29'd0, v.exp_count});
      chk("Instr_D",   idx, Instr_D,   v.exp_instr_d);
      chk("PC_D",      idx, PC_D,      v.exp_pc_d);
      chk("PCPlus4_D", idx, PCPlus4_D, v.exp_pc4_d);
      chk("PCPlus4_F", idx, PCPlus4_F, v.exp_pc4_f);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      RST     = 1'b0;
      Flush_D = 1'b0;
      Stall_D = 1'b0;
      PC_F    = 32'h10;
      Instr_F = 32'h1111_1111;

      //  rst flush stall pc            instr         pc_en vld cnt instr_d       pc_d          pc4_d        pc4_f
      add(0, 0, 0, 32'h10,       32'h1111_1111, 0, 0, 0, 32'h0,         32'h0,        32'h0,       32'h14);
      add(1, 0, 0, 32'h10,       32'h1111_1111, 1, 0, 0, 32'h0,         32'h0,        32'h0,       32'h14);
      add(1, 0, 0, 32'h0,        32'h2008_0001, 1, 1, 1, 32'h1111_1111, 32'h10,       32'h14,      32'h4);
      add(1, 0, 0, 32'h4,        32'h2009_0002, 1, 1, 1, 32'h2008_0001, 32'h0,        32'h4,       32'h8);
      add(1, 0, 0, 32'h8,        32'h200A_0003, 1, 1, 1, 32'h2009_0002, 32'h4,        32'h8,       32'hC);
      add(1, 0, 1, 32'hC,        32'h200B_0004, 1, 1, 1, 32'h200A_0003, 32'h8,        32'hC,       32'h10);
      add(1, 0, 1, 32'h10,       32'h200C_0005, 1, 1, 2, 32'h200A_0003, 32'h8,        32'hC,       32'h14);
      add(1, 0, 1, 32'h14,       32'h200D_0006, 1, 1, 3, 32'h200A_0003, 32'h8,        32'hC,       32'h18);
      add(1, 0, 1, 32'h18,       32'h200E_0007, 0, 1, 4, 32'h200A_0003, 32'h8,        32'hC,       32'h1C);
      add(1, 0, 1, 32'h18,       32'h200E_0007, 0, 1, 4, 32'h200A_0003, 32'h8,        32'hC,       32'h1C);
      add(1, 0, 1, 32'h18,       32'h200E_0007, 0, 1, 4, 32'h200A_0003, 32'h8,        32'hC,       32'h1C);
      add(1, 0, 0, 32'h18,       32'h200E_0007, 1, 1, 4, 32'h200A_0003, 32'h8,        32'hC,       32'h1C);
      add(1, 0, 0, 32'h1C,       32'h200F_0008, 1, 1, 4, 32'h200B_0004, 32'hC,        32'h10,      32'h20);
      add(1, 0, 0, 32'h20,       32'h2010_0009, 1, 1, 4, 32'h200C_0005, 32'h10,       32'h14,      32'h24);
      add(1, 0, 0, 32'h24,       32'h2011_000A, 1, 1, 4, 32'h200D_0006, 32'h14,       32'h18,      32'h28);
      add(1, 0, 0, 32'h28,       32'h2012_000B, 1, 1, 4, 32'h200E_0007, 32'h18,       32'h1C,      32'h2C);
      add(1, 1, 1, 32'h2C,       32'h2013_000C, 1, 1, 4, 32'h200F_0008, 32'h1C,       32'h20,      32'h30);
      add(1, 0, 0, 32'h40,       32'h2014_000D, 1, 0, 0, 32'h0,         32'h0,        32'h0,       32'h44);
      add(1, 0, 1, 32'h44,       32'h2015_000E, 1, 1, 1, 32'h2014_000D, 32'h40,       32'h44,      32'h48);
      add(1, 0, 1, 32'h48,       32'h2016_000F, 1, 1, 2, 32'h2014_000D, 32'h40,       32'h44,      32'h4C);
      add(1, 1, 0, 32'h4C,       32'h2017_0010, 1, 1, 3, 32'h2014_000D, 32'h40,       32'h44,      32'h50);
      add(1, 0, 1, 32'h80,       32'h2018_0011, 1, 0, 0, 32'h0,         32'h0,        32'h0,       32'h84);
      add(1, 0, 0, 32'hFFFF_FFFC, 32'h2019_0012, 1, 1, 1, 32'h2018_0011, 32'h80,       32'h84,      32'h0);
      add(1, 0, 0, 32'h0,        32'h201A_0013, 1, 1, 1, 32'h2019_0012, 32'hFFFF_FFFC, 32'h0,      32'h4);
      add(0, 0, 0, 32'h4,        32'h201B_0014, 0, 1, 1, 32'h201A_0013, 32'h0,        32'h4,       32'h8);
      add(1, 0, 0, 32'h4,        32'h201B_0014, 1, 0, 0, 32'h0,         32'h0,        32'h0,       32'h8);
      add(1, 0, 0, 32'h8,        32'h201C_0015, 1, 1, 1, 32'h201B_0014, 32'h4,        32'h8,       32'hC);

      @(posedge CLK);

      for (int i = 0; i < vec_q.size(); i++) begin
         @(negedge CLK);
         RST     = vec_q[i].rst;
         Flush_D = vec_q[i].flush;
         Stall_D = vec_q[i].stall;
         PC_F    = vec_q[i].pc;
         Instr_F = vec_q[i].instr;
         #4;
         check_all(i, vec_q[i]);
         $display("vec %0d rst=%0b flush=%0b stall=%0b pc=%08h -> en=%0b v=%0b cnt=%0d pc_d=%08h instr_d=%08h",
                  i, RST, Flush_D, Stall_D, PC_F, PC_EN, Valid_D, Count, PC_D, Instr_D);
      end

      // Reset and flush together: reset holds the PC even though a flush is requested.
      @(negedge CLK);
      RST = 1'b0; Flush_D = 1'b1; Stall_D = 1'b0;
      PC_F = 32'hC; Instr_F = 32'h201D_0016;
      #4;
      chk("PC_EN rst+flush", 100, {31'd0, PC_EN}, 32'd0);
      $display("seq rst+flush: en=%0b cnt=%0d", PC_EN, Count);

      @(negedge CLK);
      RST = 1'b1; Flush_D = 1'b0;
      PC_F = 32'hFFFF_FFFC; Instr_F = 32'h201E_0017;
      #4;
      chk("Count after rst+flush", 101, {29'd0, Count}, 32'd0);
      chk("PCPlus4_F wrap",        101, PCPlus4_F, 32'h0);
      chk("PC_EN after release",   101, {31'd0, PC_EN}, 32'd1);
      $display("seq wrap push: en=%0b cnt=%0d pc4_f=%08h", PC_EN, Count, PCPlus4_F);

      @(negedge CLK);
      PC_F = 32'h100; Instr_F = 32'h201F_0018;
      #4;
      chk("PC_D wrap head",      102, PC_D, 32'hFFFF_FFFC);
      chk("PCPlus4_D wrap head", 102, PCPlus4_D, 32'h0);
      chk("Instr_D wrap head",   102, Instr_D, 32'h201E_0017);
      $display("seq wrap head: pc_d=%08h pc4_d=%08h instr_d=%08h", PC_D, PCPlus4_D, Instr_D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch buffer between the PC register / instruction memory and the decode stage of the pipelined MIPS core.
- Each cycle it captures {PC, PC+4, instruction} into a small in-order FIFO and presents the head entry to decode with a valid/stall handshake.
- Computes PC+4 for the PC register and drives the PC register's EN input, so fetch stops only when the buffer is full.
- Handles branch flush.

Parameters:
- DEPTH, 4, number of buffered entries; power of 2, minimum 2.
- WIDTH, 32, width of address and instruction words.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset; synchronous, active-low.
- PC_F  input  WIDTH  current fetch address from the PC register.
- Instr_F  input  WIDTH  instruction-memory read data for PC_F; combinational, same cycle.
- PCPlus4_F  output  WIDTH  PC_F+4; feeds the PC register's PC_plus4 input.
- PC_EN  output  1  enable to the PC register.
- Flush_D  input  1  branch taken; discard all buffered entries.
- Stall_D  input  1  decode cannot accept the head entry this cycle.
- Valid_D  output  1  head entry valid.
- Instr_D  output  WIDTH  head instruction.
- PC_D  output  WIDTH  head instruction address.
- PCPlus4_D  output  WIDTH  head PC+4.
- Count  output  log2(DEPTH)+1  occupancy, for the hazard unit and debug.

Behaviour:
- Reset: sampled on rising CLK while RST=0.
  - Next state: wr_ptr=0, rd_ptr=0, Count=0, Valid_D=0, Instr_D/PC_D/PCPlus4_D=0.
  - While RST=0, PC_EN=0 combinationally.
  - Reset mid-operation drops all entries, exactly like a flush.
- PCPlus4_F = PC_F + 4, modulo 2^WIDTH. 0xFFFFFFFC wraps to 0x00000000. Purely combinational.
- pop = Valid_D & ~Stall_D & ~Flush_D.
- push = RST & ~Flush_D & ((Count < DEPTH) | pop).
  - Push writes {PC_F, PCPlus4_F, Instr_F} at wr_ptr.
- PC_EN = RST & (push | Flush_D). During a flush, PC_EN=1 so the PC register loads the branch target, which is selected by the PC register's own PC_Src.
- Latency:
  - Instruction fetched in cycle N is visible at the decode outputs in cycle N+1 at the earliest.
  - No same-cycle bypass.
  - Steady-state streaming (Stall_D=0) gives Count=1 and one instruction per cycle.
- Outputs:
  - Valid_D = (Count != 0).
  - Instr_D/PC_D/PCPlus4_D = entry at rd_ptr when Valid_D=1; forced to 0 when Valid_D=0 (0x00000000 is a NOP).
- Pointers: increment modulo DEPTH on push/pop respectively.
  - Count next = Count + push - pop.
- Boundary conditions:
  - Full (Count=DEPTH) with no pop: push=0, PC_EN=0, PC holds. The same Instr_F is re-presented and captured once space frees.
  - Full with pop in the same cycle: push and pop both occur, Count stays DEPTH, PC_EN=1.
  - Empty: pop impossible. Push alone gives Count=1 next cycle.
  - Flush_D=1 overrides push and pop. Next cycle: Count=0, pointers=0, Valid_D=0. The first entry after the flush is the branch-target instruction, one cycle later.
  - Flush_D and Stall_D both high: flush wins.
  - Stall_D with Valid_D=0 has no effect.
- Order: strict FIFO. No entry is lost or duplicated outside a flush or reset.

Decomposition:
- Shared package holds:
  - fetch entry typedef {pc, pc_plus4, instr};
  - NOP constant 32'h00000000;
  - PC increment constant 4;
  - default DEPTH.
- One natural sub-module: fq_storage, a DEPTH x entry register array with write-at-pointer / read-at-pointer and synchronous clear.
- Control (pointers, Count, push/pop/flush) stays in fetch_queue.

Test Plan:
1. Reset: hold RST=0 for 2 cycles with PC_F=0x10 -> PC_EN=0, Valid_D=0, Instr_D=0, Count=0. First cycle after release -> PC_EN=1.
2. Streaming: PC_F=0,4,8 with Instr_F=0x20080001,0x20090002,0x200A0003, Stall_D=0 -> from the following cycle Instr_D=0x20080001,0x20090002,0x200A0003 and PCPlus4_D=4,8,0xC, one per cycle. Count=1 throughout.
3. Fill: Stall_D=1 for 6 cycles while streaming -> Count=1,2,3,4,4,4 and PC_EN=0 once Count=4. Release Stall_D -> four entries pop in address order, then the held PC_F instruction follows with no gap or duplicate.
4. Full with simultaneous pop and push: Count=4, Stall_D falls -> Count stays 4, PC_EN=1, head advances by one.
5. Flush: Count=3, Flush_D=1 for 1 cycle -> PC_EN=1 that cycle. Next cycle Count=0, Valid_D=0, Instr_D=0. Then the branch target PC_F=0x40 appears at PC_D the cycle after.
6. Wrap: PC_F=0xFFFFFFFC -> PCPlus4_F=0x00000000, and PCPlus4_D=0 when that entry reaches the head.
